// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controllers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULTI = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int MUL_LAT_DEF = 3;
    localparam int DIV_LAT_DEF = 8;
    localparam int CNT_W       = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_raw_hazard_cmp.sv
// Combinational RAW comparator: flags a Decode source that matches the Execute producer.
module raw_hazard_cmp #(
    parameter int REG_W = 4
) (
    input  logic             validD,
    input  logic [REG_W-1:0] rs1D,
    input  logic [REG_W-1:0] rs2D,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic             validE,
    input  logic [REG_W-1:0] rdE,
    input  logic             producerE,
    output logic             hazard
);

    // Every register index is compared, r0 included: there is no hardwired zero.
    assign hazard = validE && validD && producerE &&
                    ((useRs1D && (rs1D == rdE)) || (useRs2D && (rs2D == rdE)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the Fetch/Decode/Execute pipeline: multi-cycle ops, load-use, branch flush.
// Define NO_FORWARD_EN to stall on any write-back producer (pipeline without forwarding).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int DIV_LAT    = DIV_LAT_DEF,
    parameter int BR_PENALTY = 1,
    parameter int REG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validD,
    input  logic [REG_W-1:0] rs1D,
    input  logic [REG_W-1:0] rs2D,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic             validE,
    input  logic [REG_W-1:0] rdE,
    input  logic             isWbE,
    input  logic             isLdE,
    input  logic             isMulE,
    input  logic             isDivE,
    input  logic             isModE,
    input  logic             branchTakenE,
    output logic             stallFD,
    output logic             holdDE,
    output logic             bubbleDE,
    output logic             flushFD,
    output logic [1:0]       stallC,
    output logic             busy
);

    // The first freeze cycle is spent in IDLE, so MULTI counts down from LAT-2.
    localparam logic [CNT_W-1:0] MUL_CNT   = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_CNT   = CNT_W'(DIV_LAT - 2);
    localparam logic [CNT_W-1:0] BR_CNT    = CNT_W'(BR_PENALTY - 1);
    localparam logic [1:0]       BR_STALLC = 2'(BR_PENALTY);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             producerE;
    logic             raw_hz;
    logic             branchE;
    logic             multiE;

`ifdef NO_FORWARD_EN
    assign producerE = isWbE | isLdE;
`else
    logic unused_wb;
    assign producerE = isLdE;
    assign unused_wb = isWbE;
`endif

    raw_hazard_cmp #(
        .REG_W(REG_W)
    ) u_raw_cmp (
        .validD   (validD),
        .rs1D     (rs1D),
        .rs2D     (rs2D),
        .useRs1D  (useRs1D),
        .useRs2D  (useRs2D),
        .validE   (validE),
        .rdE      (rdE),
        .producerE(producerE),
        .hazard   (raw_hz)
    );

    assign branchE = validE && branchTakenE;
    assign multiE  = validE && (isMulE || isDivE || isModE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (branchE) begin
                    if (BR_PENALTY > 1) begin
                        state_nx = FLUSH;
                        cnt_nx   = BR_CNT;
                    end
                end else if (multiE) begin
                    state_nx = MULTI;
                    cnt_nx   = (isDivE || isModE) ? DIV_CNT : MUL_CNT;
                end
            end
            MULTI: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    state_nx = IDLE;
                end
            end
            FLUSH: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held so a mid-hazard reset quiets the pipeline at once.
    always_comb begin
        stallFD  = 1'b0;
        holdDE   = 1'b0;
        bubbleDE = 1'b0;
        flushFD  = 1'b0;
        stallC   = 2'd0;
        busy     = 1'b0;
        if (reset) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (branchE) begin
                        flushFD  = 1'b1;
                        bubbleDE = 1'b1;
                        stallC   = BR_STALLC;
                    end else if (multiE) begin
                        stallFD = 1'b1;
                        holdDE  = 1'b1;
                    end else if (raw_hz) begin
                        stallFD  = 1'b1;
                        bubbleDE = 1'b1;
                    end
                end
                MULTI: begin
                    if (cnt != '0) begin
                        stallFD = 1'b1;
                        holdDE  = 1'b1;
                    end
                end
                FLUSH: begin
                    flushFD  = 1'b1;
                    bubbleDE = 1'b1;
                    stallC   = cnt[1:0];
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MUL_LAT=3, DIV_LAT=8, BR_PENALTY=3, REG_W=4).
module tb_pipe_hazard_ctrl;

    typedef enum logic [2:0] {E_NOP, E_ALU, E_LD, E_MUL, E_DIV, E_MOD, E_BR, E_BRLD} eop_t;

    typedef struct {
        eop_t       eop;
        logic [3:0] rd;
        logic       vD;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic [6:0] exp;
        string      name;
    } vec_t;

    // Packed as {stallFD, holdDE, bubbleDE, flushFD, stallC[1:0], busy}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_FRZ0 = 7'b1100000;
    localparam logic [6:0] O_FRZ  = 7'b1100001;
    localparam logic [6:0] O_END  = 7'b0000001;
    localparam logic [6:0] O_LU   = 7'b1010000;
    localparam logic [6:0] O_BR3  = 7'b0011110;
    localparam logic [6:0] O_FL2  = 7'b0011101;
    localparam logic [6:0] O_FL1  = 7'b0011011;
`ifdef NO_FORWARD_EN
    localparam logic [6:0] O_ALU  = O_LU;
`else
    localparam logic [6:0] O_ALU  = O_IDLE;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       validD, useRs1D, useRs2D, validE;
    logic [3:0] rs1D, rs2D, rdE;
    logic       isWbE, isLdE, isMulE, isDivE, isModE, branchTakenE;
    logic       stallFD, holdDE, bubbleDE, flushFD, busy;
    logic [1:0] stallC;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MUL_LAT   (3),
        .DIV_LAT   (8),
        .BR_PENALTY(3),
        .REG_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .validD      (validD),
        .rs1D        (rs1D),
        .rs2D        (rs2D),
        .useRs1D     (useRs1D),
        .useRs2D     (useRs2D),
        .validE      (validE),
        .rdE         (rdE),
        .isWbE       (isWbE),
        .isLdE       (isLdE),
        .isMulE      (isMulE),
        .isDivE      (isDivE),
        .isModE      (isModE),
        .branchTakenE(branchTakenE),
        .stallFD     (stallFD),
        .holdDE      (holdDE),
        .bubbleDE    (bubbleDE),
        .flushFD     (flushFD),
        .stallC      (stallC),
        .busy        (busy)
    );

    function automatic vec_t mkv(input eop_t eop, input logic [3:0] rd, input logic vD,
                                 input logic [3:0] rs1, input logic [3:0] rs2,
                                 input logic u1, input logic u2,
                                 input logic [6:0] exp, input string name);
        vec_t v;
        v.eop = eop; v.rd = rd; v.vD = vD; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        validE       = (v.eop != E_NOP);
        rdE          = v.rd;
        isWbE        = v.eop inside {E_ALU, E_LD, E_MUL, E_DIV, E_MOD, E_BRLD};
        isLdE        = v.eop inside {E_LD, E_BRLD};
        isMulE       = (v.eop == E_MUL);
        isDivE       = (v.eop == E_DIV);
        isModE       = (v.eop == E_MOD);
        branchTakenE = v.eop inside {E_BR, E_BRLD};
        validD       = v.vD;
        rs1D         = v.rs1;
        rs2D         = v.rs2;
        useRs1D      = v.u1;
        useRs2D      = v.u2;
    endtask

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {stallFD, holdDE, bubbleDE, flushFD, stallC, busy};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (stallFD,holdDE,bubbleDE,flushFD,stallC,busy)",
                     name, act, exp);
        end
    endtask

    task automatic check_pop();
        vec_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check(e.name, e.exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        check_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Idle and MUL with dependent in Decode: freeze only, inputs ignored in MULTI
        tbl.push_back(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_IDLE, "idle"));
        tbl.push_back(mkv(E_MUL, 3, 1, 3, 0, 1, 0, O_FRZ0, "mul_frz1"));
        tbl.push_back(mkv(E_BR,  3, 1, 3, 0, 1, 0, O_FRZ,  "mul_frz2_ignore_br"));
        tbl.push_back(mkv(E_MUL, 3, 1, 3, 0, 1, 0, O_END,  "mul_end"));
        tbl.push_back(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_IDLE, "mul_after"));
        // Load-use variants
        tbl.push_back(mkv(E_LD,  5, 1, 5, 2, 1, 1, O_LU,   "lu_rs1"));
        tbl.push_back(mkv(E_NOP, 0, 1, 5, 2, 1, 1, O_IDLE, "lu_clear"));
        tbl.push_back(mkv(E_LD,  5, 1, 6, 2, 1, 1, O_IDLE, "lu_nomatch"));
        tbl.push_back(mkv(E_LD,  5, 1, 0, 5, 1, 1, O_LU,   "lu_rs2"));
        tbl.push_back(mkv(E_LD,  5, 1, 5, 5, 0, 0, O_IDLE, "lu_unused_src"));
        tbl.push_back(mkv(E_LD,  5, 0, 5, 5, 1, 1, O_IDLE, "lu_invalid_d"));
        tbl.push_back(mkv(E_LD, 15, 1, 15, 0, 1, 0, O_LU,  "lu_r15"));
        tbl.push_back(mkv(E_LD,  0, 1, 0, 0, 1, 0, O_LU,   "lu_r0"));
        tbl.push_back(mkv(E_ALU, 5, 1, 5, 2, 1, 1, O_ALU,  "alu_dep"));
        tbl.push_back(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_IDLE, "gap"));
        // Taken branch, BR_PENALTY=3
        tbl.push_back(mkv(E_BR,  0, 0, 0, 0, 0, 0, O_BR3,  "br_c3"));
        tbl.push_back(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_FL2,  "br_c2"));
        tbl.push_back(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_FL1,  "br_c1"));
        tbl.push_back(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_IDLE, "br_c0"));
        // Branch together with load-use: flush only
        tbl.push_back(mkv(E_BRLD, 5, 1, 5, 0, 1, 0, O_BR3, "brlu_c3"));
        tbl.push_back(mkv(E_LD,   5, 1, 5, 0, 1, 0, O_FL2, "brlu_c2"));
        tbl.push_back(mkv(E_NOP,  0, 0, 0, 0, 0, 0, O_FL1, "brlu_c1"));
        tbl.push_back(mkv(E_NOP,  0, 0, 0, 0, 0, 0, O_IDLE, "brlu_c0"));
        // DIV: seven freeze cycles then release
        tbl.push_back(mkv(E_DIV, 7, 0, 0, 0, 0, 0, O_FRZ0, "div_frz1"));
        for (int i = 2; i <= 7; i++)
            tbl.push_back(mkv(E_DIV, 7, 0, 0, 0, 0, 0, O_FRZ, $sformatf("div_frz%0d", i)));
        tbl.push_back(mkv(E_DIV, 7, 0, 0, 0, 0, 0, O_END,  "div_end"));
        tbl.push_back(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_IDLE, "div_after"));

        // Reset held with hazards present on the inputs
        drive(mkv(E_LD, 5, 1, 5, 0, 1, 0, O_IDLE, ""));
        repeat (2) @(posedge clk);
        #1;
        check("reset_lu", O_IDLE);
        drive(mkv(E_BR, 0, 0, 0, 0, 0, 0, O_IDLE, ""));
        #1;
        check("reset_br", O_IDLE);
        drive(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_IDLE, ""));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_release", O_IDLE);

        foreach (tbl[i]) step(tbl[i]);

        // Reset asserted in the third freeze cycle of a modulo op
        step(mkv(E_MOD, 9, 0, 0, 0, 0, 0, O_FRZ0, "mod_frz1"));
        step(mkv(E_MOD, 9, 0, 0, 0, 0, 0, O_FRZ,  "mod_frz2"));
        step(mkv(E_MOD, 9, 0, 0, 0, 0, 0, O_FRZ,  "mod_frz3"));
        #1 reset = 1'b0;
        #1 check("mod_rst_now", O_IDLE);
        @(posedge clk);
        #1 check("mod_rst_held", O_IDLE);
        @(negedge clk);
        drive(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_IDLE, ""));
        reset = 1'b1;
        #1 check("mod_rst_release", O_IDLE);
        step(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_IDLE, "mod_rst_idle"));

        // Reset during flush
        step(mkv(E_BR,  0, 0, 0, 0, 0, 0, O_BR3, "fl_rst_c3"));
        step(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_FL2, "fl_rst_c2"));
        #1 reset = 1'b0;
        #1 check("fl_rst_now", O_IDLE);
        @(negedge clk);
        reset = 1'b1;
        #1 check("fl_rst_release", O_IDLE);
        step(mkv(E_NOP, 0, 0, 0, 0, 0, 0, O_IDLE, "fl_rst_idle"));
        step(mkv(E_LD,  4, 1, 0, 4, 0, 1, O_LU,   "fl_rst_lu"));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
